// File: rtl/control_hazard_unit.sv
// Control and hazard unit for the five-stage RSA decryption ASIP: ID decode,
// EX operand forwarding, load-use bubbles and single-slot branch squash.
module control_hazard_unit #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [2:0]   opcode,
    input  logic [1:0]   func,
    input  logic [W-1:0] ra_id,
    input  logic [W-1:0] rb_id,
    input  logic [W-1:0] rw_id,
    input  logic [W-1:0] ra_ex,
    input  logic [W-1:0] rb_ex,
    input  logic [W-1:0] rw_ex,
    input  logic [W-1:0] rw_mem,
    input  logic [W-1:0] rw_wb,
    output logic [1:0]   branch,
    output logic [1:0]   ext_sel,
    output logic         rb_sel,
    output logic         wr_en,
    output logic         opb_sel,
    output logic         alu_func,
    output logic         wd_sel,
    output logic         wm_en,
    output logic [1:0]   forward_ra,
    output logic [1:0]   forward_rb,
    output logic         stall,
    output logic         flush
);

    localparam logic [2:0] OP_ALU_REG = 3'b000;
    localparam logic [2:0] OP_ALU_IMM = 3'b001;
    localparam logic [2:0] OP_LDR     = 3'b010;
    localparam logic [2:0] OP_STR     = 3'b011;
    localparam logic [2:0] OP_B       = 3'b100;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_ex_wr;
    logic r_ex_ld;
    logic r_mem_wr;
    logic r_mem_ld;
    logic r_wb_wr;

    // Raw decode of the instruction currently in ID
    logic [1:0] w_dec_branch;
    logic [1:0] w_dec_ext_sel;
    logic       w_dec_rb_sel;
    logic       w_dec_wr_en;
    logic       w_dec_opb_sel;
    logic       w_dec_alu_func;
    logic       w_dec_wd_sel;
    logic       w_dec_wm_en;
    logic       w_dec_is_ld;
    logic       w_dec_is_b;
    logic       w_use_a;
    logic       w_use_b;
    logic [W-1:0] w_src_b;

    logic w_hazard;
    logic w_stall;
    logic w_flush;
    logic w_bubble;
    logic w_issue_wr;
    logic w_issue_ld;
    logic w_issue_b;

    // func[1] is reserved; only func[0] selects ADD/SUB
    logic w_unused;
    assign w_unused = func[1];

    always_comb begin
        w_dec_branch   = 2'b11;
        w_dec_ext_sel  = 2'b11;
        w_dec_rb_sel   = 1'b0;
        w_dec_wr_en    = 1'b0;
        w_dec_opb_sel  = 1'b0;
        w_dec_alu_func = 1'b0;
        w_dec_wd_sel   = 1'b0;
        w_dec_wm_en    = 1'b0;
        w_dec_is_ld    = 1'b0;
        w_dec_is_b     = 1'b0;
        w_use_a        = 1'b0;
        w_use_b        = 1'b0;
        w_src_b        = rb_id;
        case (opcode)
            OP_ALU_REG: begin
                w_dec_wr_en    = 1'b1;
                w_dec_alu_func = func[0];
                w_use_a        = 1'b1;
                w_use_b        = 1'b1;
            end
            OP_ALU_IMM: begin
                w_dec_ext_sel  = 2'b00;
                w_dec_opb_sel  = 1'b1;
                w_dec_wr_en    = 1'b1;
                w_dec_alu_func = func[0];
                w_use_a        = 1'b1;
            end
            OP_LDR: begin
                w_dec_ext_sel  = 2'b01;
                w_dec_opb_sel  = 1'b1;
                w_dec_wr_en    = 1'b1;
                w_dec_wd_sel   = 1'b1;
                w_dec_is_ld    = 1'b1;
                w_use_a        = 1'b1;
            end
            OP_STR: begin
                // Store data is read through port B from the rw field
                w_dec_ext_sel  = 2'b01;
                w_dec_opb_sel  = 1'b1;
                w_dec_rb_sel   = 1'b1;
                w_dec_wm_en    = 1'b1;
                w_use_a        = 1'b1;
                w_use_b        = 1'b1;
                w_src_b        = rw_id;
            end
            OP_B: begin
                w_dec_branch   = 2'b00;
                w_dec_ext_sel  = 2'b10;
                w_dec_is_b     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_hazard = r_ex_ld &
                      ((w_use_a && (rw_ex == ra_id)) ||
                       (w_use_b && (rw_ex == w_src_b)));

    // The stalled instruction re-decodes with the load already in MEM, so the
    // hazard cannot repeat; FLUSH overrides any stall request
    assign w_stall  = (r_state == ST_RUN) && w_hazard;
    assign w_flush  = (r_state == ST_FLUSH);
    assign w_bubble = reset | w_stall | w_flush;

    assign stall = w_stall;
    assign flush = w_flush;

    always_comb begin
        branch   = 2'b11;
        ext_sel  = 2'b11;
        rb_sel   = 1'b0;
        wr_en    = 1'b0;
        opb_sel  = 1'b0;
        alu_func = 1'b0;
        wd_sel   = 1'b0;
        wm_en    = 1'b0;
        if (!w_bubble) begin
            branch   = w_dec_branch;
            ext_sel  = w_dec_ext_sel;
            rb_sel   = w_dec_rb_sel;
            wr_en    = w_dec_wr_en;
            opb_sel  = w_dec_opb_sel;
            alu_func = w_dec_alu_func;
            wd_sel   = w_dec_wd_sel;
            wm_en    = w_dec_wm_en;
        end
    end

    assign w_issue_wr = !w_bubble && w_dec_wr_en;
    assign w_issue_ld = !w_bubble && w_dec_is_ld;
    assign w_issue_b  = !w_bubble && w_dec_is_b;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (w_issue_b) w_state_next = ST_FLUSH;
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_ld <= 1'b0;
            r_wb_wr  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ex_wr  <= w_issue_wr;
            r_ex_ld  <= w_issue_ld;
            r_mem_wr <= r_ex_wr;
            r_mem_ld <= r_ex_ld;
            r_wb_wr  <= r_mem_wr;
        end
    end

    // A load in MEM has no data yet, so it never forwards from the MEM ALU path
    logic [W-1:0] w_src_ex [2];
    logic [1:0]   w_fwd    [2];

    assign w_src_ex[0] = ra_ex;
    assign w_src_ex[1] = rb_ex;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                w_fwd[gi] = FWD_RF;
                if (r_mem_wr && !r_mem_ld && (rw_mem == w_src_ex[gi])) begin
                    w_fwd[gi] = FWD_MEM;
                end else if (r_wb_wr && (rw_wb == w_src_ex[gi])) begin
                    w_fwd[gi] = FWD_WB;
                end
            end
        end
    endgenerate

    assign forward_ra = w_fwd[0];
    assign forward_rb = w_fwd[1];

endmodule

// File: tb/tb_control_hazard_unit.sv
// Directed bench for control_hazard_unit: the bench plays the datapath by
// driving the EX/MEM/WB register IDs each cycle by hand.
module tb_control_hazard_unit;

    localparam int W = 5;

    logic         clock;
    logic         reset;
    logic [2:0]   opcode;
    logic [1:0]   func;
    logic [W-1:0] ra_id, rb_id, rw_id;
    logic [W-1:0] ra_ex, rb_ex, rw_ex, rw_mem, rw_wb;
    logic [1:0]   branch, ext_sel;
    logic         rb_sel, wr_en, opb_sel, alu_func, wd_sel, wm_en;
    logic [1:0]   forward_ra, forward_rb;
    logic         stall, flush;

    int checks;
    int failures;

    control_hazard_unit #(.W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .func       (func),
        .ra_id      (ra_id),
        .rb_id      (rb_id),
        .rw_id      (rw_id),
        .ra_ex      (ra_ex),
        .rb_ex      (rb_ex),
        .rw_ex      (rw_ex),
        .rw_mem     (rw_mem),
        .rw_wb      (rw_wb),
        .branch     (branch),
        .ext_sel    (ext_sel),
        .rb_sel     (rb_sel),
        .wr_en      (wr_en),
        .opb_sel    (opb_sel),
        .alu_func   (alu_func),
        .wd_sel     (wd_sel),
        .wm_en      (wm_en),
        .forward_ra (forward_ra),
        .forward_rb (forward_rb),
        .stall      (stall),
        .flush      (flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic [2:0] op, input logic [1:0] fn,
                          input logic [W-1:0] rw, input logic [W-1:0] ra,
                          input logic [W-1:0] rb);
        opcode = op;
        func   = fn;
        rw_id  = rw;
        ra_id  = ra;
        rb_id  = rb;
    endtask

    task automatic set_pipe(input logic [W-1:0] a_ex, input logic [W-1:0] b_ex,
                            input logic [W-1:0] w_ex, input logic [W-1:0] w_mem,
                            input logic [W-1:0] w_wb);
        ra_ex  = a_ex;
        rb_ex  = b_ex;
        rw_ex  = w_ex;
        rw_mem = w_mem;
        rw_wb  = w_wb;
    endtask

    // NOPs in ID for three cycles leave every shadow register at zero
    task automatic drain();
        set_id(3'b101, 2'b00, 0, 0, 0);
        set_pipe(0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(3'b000, 2'b00, 5'd0, 5'd1, 5'd2);
        set_pipe(0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            $display("FAIL reset_cycle_wr_en got=%b exp=0", wr_en);
            failures++;
        end
        checks++;
        if (ext_sel !== 2'b11 || branch !== 2'b11) begin
            $display("FAIL reset_cycle_bubble got=ext%b/br%b exp=ext11/br11", ext_sel, branch);
            failures++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b1 || alu_func !== 1'b0) begin
            $display("FAIL post_reset_add got=wr%b/alu%b exp=wr1/alu0", wr_en, alu_func);
            failures++;
        end
        checks++;
        if (ext_sel !== 2'b11 || branch !== 2'b11) begin
            $display("FAIL post_reset_add_ext got=ext%b/br%b exp=ext11/br11", ext_sel, branch);
            failures++;
        end
        checks++;
        if (stall !== 1'b0 || flush !== 1'b0) begin
            $display("FAIL post_reset_stall_flush got=st%b/fl%b exp=st0/fl0", stall, flush);
            failures++;
        end
        checks++;
        if (forward_ra !== 2'b00 || forward_rb !== 2'b00) begin
            $display("FAIL post_reset_forward got=%b/%b exp=00/00", forward_ra, forward_rb);
            failures++;
        end
        $display("test_reset done");
        drain();
    endtask

    task automatic test_forward();
        set_id(3'b000, 2'b00, 5'd1, 5'd2, 5'd3);          // ADD R1,R2,R3
        set_pipe(0, 0, 0, 0, 0);
        tick();
        set_id(3'b000, 2'b01, 5'd4, 5'd1, 5'd5);          // SUB R4,R1,R5
        set_pipe(5'd2, 5'd3, 5'd1, 0, 0);
        #1;
        checks++;
        if (alu_func !== 1'b1 || wr_en !== 1'b1 || stall !== 1'b0) begin
            $display("FAIL sub_decode got=alu%b/wr%b/st%b exp=alu1/wr1/st0", alu_func, wr_en, stall);
            failures++;
        end
        tick();
        set_id(3'b000, 2'b00, 5'd6, 5'd1, 5'd1);          // ADD R6,R1,R1
        set_pipe(5'd1, 5'd5, 5'd4, 5'd1, 0);
        #1;
        checks++;
        if (forward_ra !== 2'b01 || forward_rb !== 2'b00) begin
            $display("FAIL fwd_dist1 got=%b/%b exp=01/00", forward_ra, forward_rb);
            failures++;
        end
        tick();
        set_id(3'b101, 2'b00, 0, 0, 0);
        set_pipe(5'd1, 5'd1, 5'd6, 5'd4, 5'd1);
        #1;
        checks++;
        if (forward_ra !== 2'b10 || forward_rb !== 2'b10) begin
            $display("FAIL fwd_dist2 got=%b/%b exp=10/10", forward_ra, forward_rb);
            failures++;
        end
        $display("test_forward done");
        drain();
    endtask

    task automatic test_back_to_back();
        set_id(3'b000, 2'b00, 5'd2, 5'd1, 5'd1);
        tick();
        set_pipe(5'd1, 5'd1, 5'd2, 0, 0);
        tick();
        set_id(3'b000, 2'b00, 5'd3, 5'd2, 5'd2);
        set_pipe(5'd1, 5'd1, 5'd2, 5'd2, 0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            $display("FAIL b2b_no_stall got=%b exp=0", stall);
            failures++;
        end
        tick();
        set_id(3'b101, 2'b00, 0, 0, 0);
        set_pipe(5'd2, 5'd2, 5'd3, 5'd2, 5'd2);
        #1;
        checks++;
        if (forward_ra !== 2'b01 || forward_rb !== 2'b01) begin
            $display("FAIL fwd_mem_priority got=%b/%b exp=01/01", forward_ra, forward_rb);
            failures++;
        end
        $display("test_back_to_back done");
        drain();
    endtask

    task automatic test_load_use();
        set_id(3'b010, 2'b00, 5'd5, 5'd6, 5'd0);          // LDR R5,32(R6)
        #1;
        checks++;
        if (ext_sel !== 2'b01 || wd_sel !== 1'b1 || wr_en !== 1'b1 || opb_sel !== 1'b1) begin
            $display("FAIL ldr_decode got=ext%b/wd%b/wr%b/opb%b exp=ext01/wd1/wr1/opb1",
                     ext_sel, wd_sel, wr_en, opb_sel);
            failures++;
        end
        tick();
        set_id(3'b000, 2'b00, 5'd7, 5'd5, 5'd1);          // ADD R7,R5,R1
        set_pipe(5'd6, 5'd0, 5'd5, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            $display("FAIL load_use_stall got=%b exp=1", stall);
            failures++;
        end
        checks++;
        if (wr_en !== 1'b0 || ext_sel !== 2'b11 || branch !== 2'b11) begin
            $display("FAIL load_use_bubble got=wr%b/ext%b/br%b exp=wr0/ext11/br11", wr_en, ext_sel, branch);
            failures++;
        end
        tick();
        set_pipe(5'd5, 5'd0, 5'd0, 5'd5, 0);              // load in MEM, bubble in EX
        #1;
        checks++;
        if (stall !== 1'b0 || wr_en !== 1'b1) begin
            $display("FAIL load_use_release got=st%b/wr%b exp=st0/wr1", stall, wr_en);
            failures++;
        end
        checks++;
        if (forward_ra !== 2'b00) begin
            $display("FAIL no_fwd_from_mem_load got=%b exp=00", forward_ra);
            failures++;
        end
        tick();
        set_id(3'b101, 2'b00, 0, 0, 0);
        set_pipe(5'd5, 5'd1, 5'd7, 5'd0, 5'd5);
        #1;
        checks++;
        if (forward_ra !== 2'b10 || forward_rb !== 2'b00) begin
            $display("FAIL load_fwd_wb got=%b/%b exp=10/00", forward_ra, forward_rb);
            failures++;
        end
        $display("test_load_use done");
        drain();
    endtask

    task automatic test_store();
        set_id(3'b010, 2'b00, 5'd5, 5'd6, 5'd0);          // LDR R5
        tick();
        set_id(3'b011, 2'b00, 5'd5, 5'd2, 5'd9);          // STR R5,0(R2)
        set_pipe(5'd6, 5'd0, 5'd5, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b1 || wm_en !== 1'b0) begin
            $display("FAIL store_data_stall got=st%b/wm%b exp=st1/wm0", stall, wm_en);
            failures++;
        end
        tick();
        set_pipe(0, 0, 0, 5'd5, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || wm_en !== 1'b1 || rb_sel !== 1'b1 || ext_sel !== 2'b01 || wr_en !== 1'b0) begin
            $display("FAIL str_decode got=st%b/wm%b/rbs%b/ext%b/wr%b exp=st0/wm1/rbs1/ext01/wr0",
                     stall, wm_en, rb_sel, ext_sel, wr_en);
            failures++;
        end
        $display("test_store done");
        drain();
        set_id(3'b010, 2'b00, 5'd5, 5'd6, 5'd0);          // LDR R5
        tick();
        set_id(3'b001, 2'b00, 5'd8, 5'd1, 5'd5);          // ADDI R8,R1 with rb field = R5
        set_pipe(5'd6, 5'd0, 5'd5, 0, 0);
        #1;
        checks++;
        if (stall !== 1'b0 || ext_sel !== 2'b00 || opb_sel !== 1'b1 || wr_en !== 1'b1) begin
            $display("FAIL addi_no_false_stall got=st%b/ext%b/opb%b/wr%b exp=st0/ext00/opb1/wr1",
                     stall, ext_sel, opb_sel, wr_en);
            failures++;
        end
        $display("test_no_false_stall done");
        drain();
    endtask

    task automatic test_branch();
        set_id(3'b100, 2'b00, 0, 0, 0);                   // B
        #1;
        checks++;
        if (branch !== 2'b00 || ext_sel !== 2'b10 || flush !== 1'b0 || wr_en !== 1'b0) begin
            $display("FAIL b_decode got=br%b/ext%b/fl%b/wr%b exp=br00/ext10/fl0/wr0",
                     branch, ext_sel, flush, wr_en);
            failures++;
        end
        tick();
        set_id(3'b100, 2'b00, 0, 0, 0);                   // another B, must be squashed
        set_pipe(0, 0, 5'd0, 0, 0);
        #1;
        checks++;
        if (flush !== 1'b1 || stall !== 1'b0 || branch !== 2'b11 || ext_sel !== 2'b11) begin
            $display("FAIL flush_slot got=fl%b/st%b/br%b/ext%b exp=fl1/st0/br11/ext11",
                     flush, stall, branch, ext_sel);
            failures++;
        end
        tick();
        set_id(3'b000, 2'b00, 5'd3, 5'd1, 5'd2);
        #1;
        checks++;
        if (flush !== 1'b0 || wr_en !== 1'b1) begin
            $display("FAIL flush_return_run got=fl%b/wr%b exp=fl0/wr1", flush, wr_en);
            failures++;
        end
        $display("test_branch done");
        drain();
    endtask

    task automatic test_reset_in_flush();
        set_id(3'b000, 2'b00, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(3'b000, 2'b00, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(3'b100, 2'b00, 0, 0, 0);
        tick();
        reset = 1'b1;
        set_id(3'b101, 2'b00, 0, 0, 0);
        #1;
        checks++;
        if (flush !== 1'b1) begin
            $display("FAIL flush_before_reset got=%b exp=1", flush);
            failures++;
        end
        tick();
        reset = 1'b0;
        set_id(3'b000, 2'b00, 5'd4, 5'd5, 5'd5);
        set_pipe(5'd1, 5'd1, 5'd5, 5'd1, 5'd1);
        #1;
        checks++;
        if (flush !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL reset_clears_flush got=fl%b/st%b exp=fl0/st0", flush, stall);
            failures++;
        end
        checks++;
        if (forward_ra !== 2'b00 || forward_rb !== 2'b00) begin
            $display("FAIL reset_clears_shadow got=%b/%b exp=00/00", forward_ra, forward_rb);
            failures++;
        end
        checks++;
        if (wr_en !== 1'b1) begin
            $display("FAIL decode_after_reset got=%b exp=1", wr_en);
            failures++;
        end
        $display("test_reset_in_flush done");
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_id(3'b101, 2'b00, 0, 0, 0);
        set_pipe(0, 0, 0, 0, 0);
        test_reset();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_store();
        test_branch();
        test_reset_in_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
